// File: rtl/present_core.sv
// rtl/present_core.sv - iterative PRESENT block cipher core, one round per clock
module present_core #(
    parameter int KEY_WIDTH = 80,
    parameter int ROUNDS    = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_data,
    input  logic [KEY_WIDTH-1:0] in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    fsm_e                 fsm_q;
    logic [63:0]          state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [4:0]           cnt_q;
    logic [63:0]          out_data_q;
    logic                 out_valid_q;
    logic [63:0]          ark, sbl;

    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_core: ROUNDS must be in 1..31");
    end

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    // Data path: addRoundKey, sBoxLayer, pLayer (bit i -> 16*i mod 63, bit 63 fixed)
    always_comb begin
        ark     = state_q ^ key_q[KEY_WIDTH-1 -: 64];
        sbl     = '0;
        state_d = '0;
        for (int n = 0; n < 16; n++) begin
            sbl[4*n +: 4] = sbox(ark[4*n +: 4]);
        end
        for (int i = 0; i < 63; i++) begin
            state_d[(16*i) % 63] = sbl[i];
        end
        state_d[63] = sbl[63];
    end

    if (KEY_WIDTH == 80) begin : g_key80
        always_comb begin
            key_d          = {key_q[18:0], key_q[79:19]};
            key_d[79:76]   = sbox(key_d[79:76]);
            key_d[19:15]   = key_d[19:15] ^ cnt_q;
        end
    end else if (KEY_WIDTH == 128) begin : g_key128
        always_comb begin
            key_d          = {key_q[66:0], key_q[127:67]};
            key_d[127:124] = sbox(key_d[127:124]);
            key_d[123:120] = sbox(key_d[123:120]);
            key_d[66:62]   = key_d[66:62] ^ cnt_q;
        end
    end else begin : g_bad_key
        $error("present_core: KEY_WIDTH must be 80 or 128");
        always_comb key_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_data;
                        key_q   <= in_key;
                        cnt_q   <= 5'd1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    key_q   <= key_d;
                    // Final round folds in the last round key; counter parks at ROUNDS
                    if (cnt_q == LAST_ROUND) begin
                        out_data_q  <= state_d ^ key_d[KEY_WIDTH-1 -: 64];
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
